// File: rtl/fifo_arb_pkg.sv
// Shared widths, state encoding and sizing helper for the fifo write-port arbiter.
package fifo_arb_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned COUNT_W = 5;

    typedef enum logic {IDLE, BURST} arb_state_t;

    // Index width that stays legal (>= 1 bit) even for a single-entry range.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority encoder; first set request at or after rr_ptr.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               hit,
    output logic [IDX_W-1:0]   index
);

    int unsigned    pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        hit     = 1'b0;
        index   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos     = (32'(rr_ptr) + i) % NUM_REQ;
            pos_idx = IDX_W'(pos);
            if (!hit && req[pos_idx]) begin
                hit   = 1'b1;
                index = pos_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for a shared 8-bit fifo write port with back-pressure.
// Optional macro FIFO_ARB_PRIO_EN: requester 0 wins every idle arbitration it takes part in.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned MAX_DATA  = 16,
    localparam int unsigned IDX_W    = idx_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wen,
    output logic [DATA_W-1:0]         fifo_wdata,
    input  logic [COUNT_W-1:0]        fifo_count,
    input  logic                      fifo_full,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    localparam int unsigned CNT_W = idx_width(BURST_LEN);
    localparam logic [CNT_W-1:0]   LastBeat = CNT_W'(BURST_LEN - 1);
    localparam logic [COUNT_W:0]   MaxLevel = (COUNT_W + 1)'(MAX_DATA);
    localparam logic [IDX_W-1:0]   LastIdx  = IDX_W'(NUM_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              pick_hit;
    logic [IDX_W-1:0]  pick_idx, sel_idx, next_ptr;
    logic [COUNT_W:0]  occupancy;
    logic              space_ok, gnt_valid, transfer;
    logic [DATA_W-1:0] gnt_data;

    rr_picker #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req   (req_valid),
        .rr_ptr(rr_ptr_q),
        .hit   (pick_hit),
        .index (pick_idx)
    );

`ifdef FIFO_ARB_PRIO_EN
    assign sel_idx = req_valid[0] ? '0 : pick_idx;
`else
    assign sel_idx = pick_idx;
`endif

    // The write still in the output register is counted; a concurrent read is not.
    assign occupancy = {1'b0, fifo_count} + {{COUNT_W{1'b0}}, wen_q};
    assign space_ok  = !fifo_full && (occupancy < MaxLevel);
    assign gnt_valid = req_valid[grant_q];
    assign gnt_data  = req_data[grant_q*DATA_W +: DATA_W];
    assign next_ptr  = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        beat_d    = beat_q;
        wen_d     = 1'b0;
        wdata_d   = wdata_q;
        req_ready = '0;
        transfer  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    grant_d = sel_idx;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                req_ready[grant_q] = space_ok;
                transfer           = gnt_valid && space_ok;
                if (transfer) begin
                    wen_d   = 1'b1;
                    wdata_d = gnt_data;
                    beat_d  = beat_q + 1'b1;
                end
                if ((transfer && (beat_q == LastBeat)) || !gnt_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
        end
    end

    assign fifo_wen   = wen_q;
    assign fifo_wdata = wdata_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wen;
    logic [7:0]  fifo_wdata;
    logic [4:0]  fifo_count;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ  (4),
        .BURST_LEN(4),
        .MAX_DATA (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_wen  (fifo_wen),
        .fifo_wdata(fifo_wdata),
        .fifo_count(fifo_count),
        .fifo_full (fifo_full),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    typedef struct packed {
        logic [3:0] valid;
        logic [7:0] data;
        logic [4:0] count;
        logic       full;
        logic [3:0] e_ready;
        logic       e_wen;
        logic [7:0] e_wdata;
        logic [1:0] e_grant;
        logic       e_busy;
    } vec_t;

    vec_t vecs [0:22];

    function automatic vec_t mk(input logic [3:0] v, input logic [7:0] d, input logic [4:0] c,
                                input logic f, input logic [3:0] er, input logic ew,
                                input logic [7:0] ed, input logic [1:0] eg, input logic eb);
        vec_t r;
        r = '{v, d, c, f, er, ew, ed, eg, eb};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] e_ready, input logic e_wen,
                              input logic [7:0] e_wdata, input logic [1:0] e_grant,
                              input logic e_busy);
        check({tag, " ready"}, 32'(req_ready), 32'(e_ready));
        check({tag, " wen"},   32'(fifo_wen),  32'(e_wen));
        if (e_wen) check({tag, " wdata"}, 32'(fifo_wdata), 32'(e_wdata));
        check({tag, " grant"}, 32'(grant_id),  32'(e_grant));
        check({tag, " busy"},  32'(busy),      32'(e_busy));
    endtask

    int         seq [4];
    int         g;
    int         prev_g;
    logic       exp_wen;
    logic [7:0] exp_wdata;

    task automatic fill_seq_data();
        for (int r = 0; r < 4; r++) req_data[8*r +: 8] = 8'(r * 16 + seq[r]);
    endtask

    initial begin
        // Only requester 2, then requester 1 against a nearly full fifo, then 0 with full flag.
        vecs[0]  = mk(4'b0100, 8'hA0, 5'd0,  1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[1]  = mk(4'b0100, 8'hA0, 5'd0,  1'b0, 4'b0100, 1'b0, 8'h00, 2'd2, 1'b1);
        vecs[2]  = mk(4'b0100, 8'hA1, 5'd0,  1'b0, 4'b0100, 1'b1, 8'hA0, 2'd2, 1'b1);
        vecs[3]  = mk(4'b0100, 8'hA2, 5'd0,  1'b0, 4'b0100, 1'b1, 8'hA1, 2'd2, 1'b1);
        vecs[4]  = mk(4'b0100, 8'hA3, 5'd0,  1'b0, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1);
        vecs[5]  = mk(4'b0100, 8'hA4, 5'd0,  1'b0, 4'b0000, 1'b1, 8'hA3, 2'd2, 1'b0);
        vecs[6]  = mk(4'b0100, 8'hA4, 5'd0,  1'b0, 4'b0100, 1'b0, 8'h00, 2'd2, 1'b1);
        vecs[7]  = mk(4'b0000, 8'h00, 5'd0,  1'b0, 4'b0100, 1'b1, 8'hA4, 2'd2, 1'b1);
        vecs[8]  = mk(4'b0000, 8'h00, 5'd0,  1'b0, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0);
        vecs[9]  = mk(4'b0010, 8'hB0, 5'd15, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0);
        vecs[10] = mk(4'b0010, 8'hB0, 5'd15, 1'b0, 4'b0010, 1'b0, 8'h00, 2'd1, 1'b1);
        vecs[11] = mk(4'b0010, 8'hB1, 5'd15, 1'b0, 4'b0000, 1'b1, 8'hB0, 2'd1, 1'b1);
        vecs[12] = mk(4'b0010, 8'hB1, 5'd16, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b1);
        vecs[13] = mk(4'b0010, 8'hB1, 5'd16, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b1);
        vecs[14] = mk(4'b0010, 8'hB1, 5'd14, 1'b0, 4'b0010, 1'b0, 8'h00, 2'd1, 1'b1);
        vecs[15] = mk(4'b0010, 8'hB2, 5'd14, 1'b0, 4'b0010, 1'b1, 8'hB1, 2'd1, 1'b1);
        vecs[16] = mk(4'b0000, 8'h00, 5'd14, 1'b0, 4'b0010, 1'b1, 8'hB2, 2'd1, 1'b1);
        vecs[17] = mk(4'b0000, 8'h00, 5'd0,  1'b0, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0);
        vecs[18] = mk(4'b0001, 8'hC0, 5'd3,  1'b1, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0);
        vecs[19] = mk(4'b0001, 8'hC0, 5'd3,  1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1);
        vecs[20] = mk(4'b0001, 8'hC0, 5'd3,  1'b0, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1);
        vecs[21] = mk(4'b0000, 8'h00, 5'd3,  1'b0, 4'b0001, 1'b1, 8'hC0, 2'd0, 1'b1);
        vecs[22] = mk(4'b0000, 8'h00, 5'd0,  1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);

        // Reset held with every requester valid.
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_data   = 32'h5A5A5A5A;
        fifo_count = 5'd0;
        fifo_full  = 1'b0;
        #2;
        check_outs("rst async", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        check("rst async wdata", 32'(fifo_wdata), 32'h0);
        @(negedge clk);
        #1;
        check_outs("rst clocked", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        check("rst clocked wdata", 32'(fifo_wdata), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0000;

        for (int i = 0; i <= 22; i++) begin
            @(negedge clk);
            req_valid  = vecs[i].valid;
            req_data   = {4{vecs[i].data}};
            fifo_count = vecs[i].count;
            fifo_full  = vecs[i].full;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_wen,
                       vecs[i].e_wdata, vecs[i].e_grant, vecs[i].e_busy);
        end

        // All requesters valid from reset, fifo kept drained.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n      = 1'b1;
        fifo_count = 5'd0;
        fifo_full  = 1'b0;
        for (int r = 0; r < 4; r++) seq[r] = 0;
        prev_g    = 0;
        exp_wen   = 1'b0;
        exp_wdata = 8'h00;
        for (int b = 0; b < 5; b++) begin
`ifdef FIFO_ARB_PRIO_EN
            g = 0;
`else
            g = b % 4;
`endif
            @(negedge clk);
            req_valid = 4'b1111;
            fill_seq_data();
            #1;
            check_outs($sformatf("rr%0d idle", b), 4'b0000, exp_wen, exp_wdata, 2'(prev_g),
                       1'b0);
            exp_wen = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                fill_seq_data();
                #1;
                check_outs($sformatf("rr%0d beat%0d", b, k), 4'(1 << g), exp_wen, exp_wdata,
                           2'(g), 1'b1);
                exp_wen   = 1'b1;
                exp_wdata = 8'(g * 16 + seq[g]);
                seq[g]++;
            end
            prev_g = g;
        end

        // Requester 3 bursts, reset lands with its second write pending.
        @(negedge clk);
        req_valid = 4'b1000;
        req_data  = {4{8'hD0}};
        #1;
        check_outs("mid idle", 4'b0000, exp_wen, exp_wdata, 2'(prev_g), 1'b0);
        @(negedge clk);
        #1;
        check_outs("mid beat1", 4'b1000, 1'b0, 8'h00, 2'd3, 1'b1);
        @(negedge clk);
        req_data = {4{8'hD1}};
        #1;
        check_outs("mid beat2", 4'b1000, 1'b1, 8'hD0, 2'd3, 1'b1);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 4'b1001;
        req_data  = {4{8'hE0}};
        #1;
        check_outs("mid reset", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        check("mid reset wdata", 32'(fifo_wdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("post rst idle", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        #1;
        check_outs("post rst grant", 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        check_outs("post rst drop", 4'b0001, 1'b1, 8'hE0, 2'd0, 1'b1);

        // rr_ptr now 1: requesters 0 and 2 compete.
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        check_outs("prio idle", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        @(negedge clk);
        #1;
`ifdef FIFO_ARB_PRIO_EN
        check_outs("prio grant", 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1);
`else
        check_outs("prio grant", 4'b0100, 1'b0, 8'h00, 2'd2, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
